// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer types and default sizing
// Contents: default DEPTH/TAG_W/WAKE_PORTS/RETIRE_W constants, index and tag
// typedefs, and the rob_entry_t record (valid, done, has_rd, old_tag).
package rob_pkg;

  localparam int ROB_DEPTH      = 64;
  localparam int ROB_IDX_W      = $clog2(ROB_DEPTH);
  localparam int ROB_TAG_W      = 6;
  localparam int ROB_WAKE_PORTS = 4;
  localparam int ROB_RETIRE_W   = 2;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     has_rd;
    rob_tag_t old_tag;
  } rob_entry_t;

endpackage

// File: rtl/rob_param_if.sv
// rtl/rob_param_if.sv - reorder buffer allocate / wakeup / retire bundle
// master: rename/completion side (drives enq_*, wake_*; sees ready, index,
//         retire slots, occupancy).
// slave:  the reorder buffer itself.
// Retire slot r lives at [r*TAG_W +: TAG_W] / [r*IDX_W +: IDX_W]; wakeup
// port p at [p*IDX_W +: IDX_W].
interface rob_param_if
  import rob_pkg::*;
#(
  parameter int IDX_W      = ROB_IDX_W,
  parameter int TAG_W      = ROB_TAG_W,
  parameter int WAKE_PORTS = ROB_WAKE_PORTS,
  parameter int RETIRE_W   = ROB_RETIRE_W
);

  logic                         enq_valid;
  logic                         enq_ready;
  logic                         enq_has_rd;
  logic [TAG_W-1:0]             enq_old_tag;
  logic [IDX_W-1:0]             enq_index;
  logic [WAKE_PORTS-1:0]        wake_valid;
  logic [WAKE_PORTS*IDX_W-1:0]  wake_index;
  logic [RETIRE_W-1:0]          ret_valid;
  logic [RETIRE_W-1:0]          ret_free;
  logic [RETIRE_W*TAG_W-1:0]    ret_tag;
  logic [RETIRE_W*IDX_W-1:0]    ret_index;
  logic [IDX_W:0]               count;
  logic                         empty;

  modport master (
    output enq_valid, enq_has_rd, enq_old_tag, wake_valid, wake_index,
    input  enq_ready, enq_index, ret_valid, ret_free, ret_tag, ret_index,
           count, empty
  );

  modport slave (
    input  enq_valid, enq_has_rd, enq_old_tag, wake_valid, wake_index,
    output enq_ready, enq_index, ret_valid, ret_free, ret_tag, ret_index,
           count, empty
  );

endinterface

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - combinational in-order retire window scan
// Inputs:  head (oldest entry), valid/done per-entry vectors.
// Outputs: ret_cnt (0..RETIRE_W), ret_mask (thermometer, bit r = slot r
//          retires), slot_index (head+r modulo DEPTH for every slot).
module rob_retire_select
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int RETIRE_W = ROB_RETIRE_W
) (
  input  logic [IDX_W-1:0]             head,
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0]             done,
  output logic [$clog2(RETIRE_W+1)-1:0] ret_cnt,
  output logic [RETIRE_W-1:0]          ret_mask,
  output logic [RETIRE_W*IDX_W-1:0]    slot_index
);

  localparam int CNT_W = $clog2(RETIRE_W + 1);

  always_comb begin : scan
    logic             run;
    logic [IDX_W-1:0] idx;
    run        = 1'b1;
    idx        = '0;
    ret_cnt    = '0;
    ret_mask   = '0;
    slot_index = '0;
    for (int r = 0; r < RETIRE_W; r++) begin
      // IDX_W-wide add wraps past DEPTH-1 because DEPTH is a power of two.
      idx                            = head + IDX_W'(r);
      slot_index[r*IDX_W +: IDX_W]   = idx;
      // Once one entry is not ready, everything younger must wait.
      run                            = run & valid[idx] & done[idx];
      ret_mask[r]                    = run;
      if (run) ret_cnt = ret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer (in-order alloc/retire)
// Ports: clk, reset (async, active-high), flush (only with ROB_FLUSH_EN),
//        rob (rob_param_if.slave: enq_*, wake_*, ret_*, count, empty).
// Build option: define ROB_FLUSH_EN to add the flush port, which clears all
// entries and pointers at an edge and overrides enqueue, wakeup and retire.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int TAG_W      = ROB_TAG_W,
  parameter int WAKE_PORTS = ROB_WAKE_PORTS,
  parameter int RETIRE_W   = ROB_RETIRE_W
) (
  input logic        clk,
  input logic        reset,
`ifdef ROB_FLUSH_EN
  input logic        flush,
`endif
  rob_param_if.slave rob
);

  localparam int CNT_W = $clog2(RETIRE_W + 1);
  localparam int OCC_W = IDX_W + 1;

  logic [IDX_W-1:0]          head_q;
  logic [IDX_W-1:0]          tail_q;
  logic [OCC_W-1:0]          count_q;
  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          done_q;
  logic                      has_rd_q  [DEPTH];
  logic [TAG_W-1:0]          old_tag_q [DEPTH];

  logic [RETIRE_W-1:0]       ret_valid_q;
  logic [RETIRE_W-1:0]       ret_free_q;
  logic [RETIRE_W*TAG_W-1:0] ret_tag_q;
  logic [RETIRE_W*IDX_W-1:0] ret_index_q;

  logic                      enq_ready;
  logic                      enq_fire;
  logic [CNT_W-1:0]          ret_cnt;
  logic [RETIRE_W-1:0]       ret_mask;
  logic [RETIRE_W*IDX_W-1:0] slot_index;

  // Full is judged on registered occupancy only, so a retire in the same
  // cycle never opens a slot early.
  assign enq_ready = (count_q != OCC_W'(DEPTH));
  assign enq_fire  = rob.enq_valid & enq_ready;

  rob_retire_select #(
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .RETIRE_W (RETIRE_W)
  ) u_retire_select (
    .head       (head_q),
    .valid      (valid_q),
    .done       (done_q),
    .ret_cnt    (ret_cnt),
    .ret_mask   (ret_mask),
    .slot_index (slot_index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      ret_valid_q <= '0;
      ret_free_q  <= '0;
      ret_tag_q   <= '0;
      ret_index_q <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      ret_valid_q <= '0;
      ret_free_q  <= '0;
      ret_tag_q   <= '0;
      ret_index_q <= '0;
    end
`endif
    else begin
      for (int r = 0; r < RETIRE_W; r++) begin
        ret_valid_q[r] <= ret_mask[r];
        ret_free_q[r]  <= ret_mask[r] & has_rd_q[slot_index[r*IDX_W +: IDX_W]];
        ret_tag_q[r*TAG_W +: TAG_W] <=
          (ret_mask[r] && has_rd_q[slot_index[r*IDX_W +: IDX_W]])
            ? old_tag_q[slot_index[r*IDX_W +: IDX_W]] : '0;
        ret_index_q[r*IDX_W +: IDX_W] <=
          ret_mask[r] ? slot_index[r*IDX_W +: IDX_W] : '0;
        if (ret_mask[r]) valid_q[slot_index[r*IDX_W +: IDX_W]] <= 1'b0;
      end

      // Wakeups only mark entries that were allocated before this edge; a
      // duplicate index across ports simply writes the same bit twice.
      for (int p = 0; p < WAKE_PORTS; p++) begin
        if (rob.wake_valid[p] && valid_q[rob.wake_index[p*IDX_W +: IDX_W]])
          done_q[rob.wake_index[p*IDX_W +: IDX_W]] <= 1'b1;
      end

      // The tail slot is never valid while enq_ready is high, so this write
      // cannot collide with a retire or a wakeup above.
      if (enq_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + IDX_W'(1);
      end

      head_q  <= head_q + IDX_W'(ret_cnt);
      count_q <= count_q + OCC_W'(enq_fire) - OCC_W'(ret_cnt);
    end
  end

  // Payload is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      has_rd_q[tail_q]  <= rob.enq_has_rd;
      old_tag_q[tail_q] <= rob.enq_old_tag;
    end
  end

  assign rob.enq_ready = enq_ready;
  assign rob.enq_index = tail_q;
  assign rob.count     = count_q;
  assign rob.empty     = (count_q == '0);
  assign rob.ret_valid = ret_valid_q;
  assign rob.ret_free  = ret_free_q;
  assign rob.ret_tag   = ret_tag_q;
  assign rob.ret_index = ret_index_q;

endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - randomized and directed bench for rob_param
module tb_rob_param;
  import rob_pkg::*;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;
  localparam int TAG_W = 6;
  localparam int WP    = 4;
  localparam int RW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rob_param_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WAKE_PORTS(WP), .RETIRE_W(RW)) bus ();

`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif

  rob_param #(
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .WAKE_PORTS (WP),
    .RETIRE_W   (RW)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef ROB_FLUSH_EN
    .flush (flush),
`endif
    .rob   (bus)
  );

  // Reference model: the occupied part of the buffer as an age-ordered queue.
  rob_entry_t          mq[$];
  int                  head_m;
  logic [RW-1:0]       exp_rv, exp_rf;
  logic [RW*TAG_W-1:0] exp_rt;
  logic [RW*IDX_W-1:0] exp_ri;
  int                  n_cmp = 0;
  int                  n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    head_m = 0;
    exp_rv = '0; exp_rf = '0; exp_rt = '0; exp_ri = '0;
  endtask

  task automatic compare_all();
    check("count",     64'(bus.count),     64'(mq.size()));
    check("empty",     64'(bus.empty),     64'(mq.size() == 0));
    check("enq_ready", 64'(bus.enq_ready), 64'(mq.size() < DEPTH));
    check("enq_index", 64'(bus.enq_index), 64'((head_m + mq.size()) % DEPTH));
    check("ret_valid", 64'(bus.ret_valid), 64'(exp_rv));
    check("ret_free",  64'(bus.ret_free),  64'(exp_rf));
    check("ret_tag",   64'(bus.ret_tag),   64'(exp_rt));
    check("ret_index", 64'(bus.ret_index), 64'(exp_ri));
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 ns later.
  task automatic step(input logic ev, input logic ehr, input logic [TAG_W-1:0] etag,
                      input logic [WP-1:0] wv, input logic [WP*IDX_W-1:0] wi,
                      input logic fl);
    int sz, n, pos;
    logic stop;
    rob_entry_t e;
    @(negedge clk);
    bus.enq_valid   = ev;
    bus.enq_has_rd  = ehr;
    bus.enq_old_tag = etag;
    bus.wake_valid  = wv;
    bus.wake_index  = wi;
`ifdef ROB_FLUSH_EN
    flush = fl;
`endif
    @(posedge clk);
    exp_rv = '0; exp_rf = '0; exp_rt = '0; exp_ri = '0;
    sz = mq.size();
    n  = 0;
    stop = 1'b0;
    if (fl) begin
      model_clear();
    end else begin
      // Oldest-first: retire while the front entries are already complete.
      for (int r = 0; r < RW; r++) begin
        if (r >= sz) stop = 1'b1;
        else if (!mq[r].done) stop = 1'b1;
        if (!stop) begin
          exp_rv[r] = 1'b1;
          exp_rf[r] = mq[r].has_rd;
          exp_rt[r*TAG_W +: TAG_W] = mq[r].has_rd ? mq[r].old_tag : '0;
          exp_ri[r*IDX_W +: IDX_W] = IDX_W'((head_m + r) % DEPTH);
          n++;
        end
      end
      for (int p = 0; p < WP; p++) begin
        if (wv[p]) begin
          pos = (int'(wi[p*IDX_W +: IDX_W]) - head_m + DEPTH) % DEPTH;
          if (pos < sz) mq[pos].done = 1'b1;
        end
      end
      repeat (n) void'(mq.pop_front());
      head_m = (head_m + n) % DEPTH;
      if (ev && sz < DEPTH) begin
        e.valid = 1'b1; e.done = 1'b0; e.has_rd = ehr; e.old_tag = etag;
        mq.push_back(e);
      end
    end
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic enq(input logic hr, input logic [TAG_W-1:0] t);
    step(1'b1, hr, t, '0, '0, 1'b0);
  endtask

  task automatic wake1(input int port, input int idx);
    logic [WP-1:0]       v;
    logic [WP*IDX_W-1:0] w;
    v = '0; w = '0;
    v[port] = 1'b1;
    w[port*IDX_W +: IDX_W] = IDX_W'(idx);
    step(1'b0, 1'b0, '0, v, w, 1'b0);
  endtask

  // Wake the oldest entries every cycle until the buffer empties (bounded).
  task automatic drain();
    logic [WP-1:0]       v;
    logic [WP*IDX_W-1:0] w;
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 200) begin
      v = '0; w = '0;
      for (int p = 0; p < WP; p++) begin
        if (p < mq.size()) begin
          v[p] = 1'b1;
          w[p*IDX_W +: IDX_W] = IDX_W'((head_m + p) % DEPTH);
        end
      end
      step(1'b0, 1'b0, '0, v, w, 1'b0);
      guard++;
    end
    check("drain_empty", 64'(bus.empty), 64'(1));
  endtask

  logic [WP-1:0]       rv;
  logic [WP*IDX_W-1:0] rw;
  int                  nfill;

  initial begin
    bus.enq_valid = 1'b0; bus.enq_has_rd = 1'b0; bus.enq_old_tag = '0;
    bus.wake_valid = '0;  bus.wake_index = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_ret_valid", 64'(bus.ret_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Three allocations, then out-of-order completion.
    enq(1'b1, 6'd10);
    enq(1'b1, 6'd11);
    enq(1'b1, 6'd12);
    check("tp_count3", 64'(bus.count), 64'(3));
    wake1(0, 1);
    check("tp_no_ret_a", 64'(bus.ret_valid), 64'(0));
    wake1(1, 0);
    check("tp_no_ret_b", 64'(bus.ret_valid), 64'(0));
    idle();
    check("tp_pair_valid", 64'(bus.ret_valid), 64'(2'b11));
    check("tp_pair_tag",   64'(bus.ret_tag),   64'({6'd11, 6'd10}));
    check("tp_pair_index", 64'(bus.ret_index), 64'({6'd1, 6'd0}));
    check("tp_pair_count", 64'(bus.count),     64'(1));
    drain();

    // Fill to capacity; a further allocation and one during a retire are dropped.
    repeat (DEPTH) enq(1'($urandom_range(0, 1)), TAG_W'($urandom));
    check("full_ready", 64'(bus.enq_ready), 64'(0));
    enq(1'b1, 6'd5);
    wake1(2, head_m);
    step(1'b1, 1'b1, 6'd7, '0, '0, 1'b0);
    check("full_count63", 64'(bus.count),     64'(63));
    check("full_ready63", 64'(bus.enq_ready), 64'(1));
    drain();

    // Move head to 62, then retire across the wrap point.
    nfill = (62 - head_m + DEPTH) % DEPTH;
    repeat (nfill) enq(1'b1, 6'd1);
    drain();
    check("wrap_start", 64'(bus.enq_index), 64'(62));
    enq(1'b1, 6'd20); enq(1'b1, 6'd21); enq(1'b1, 6'd22);
    rv = 4'b0111; rw = '0;
    rw[0*IDX_W +: IDX_W] = 6'd62; rw[1*IDX_W +: IDX_W] = 6'd63; rw[2*IDX_W +: IDX_W] = 6'd0;
    step(1'b0, 1'b0, '0, rv, rw, 1'b0);
    idle();
    check("wrap_first",  64'(bus.ret_index), 64'({6'd63, 6'd62}));
    idle();
    check("wrap_second", 64'(bus.ret_valid), 64'(2'b01));
    check("wrap_idx0",   64'(bus.ret_index), 64'(0));
    check("wrap_head1",  64'(bus.enq_index), 64'(1));

    // Duplicate wakeups, stray wakeup, and an entry with no destination.
    repeat (4) enq(1'b1, 6'd2);
    drain();
    enq(1'b0, 6'd33);
    wake1(0, 40);
    check("stray_count", 64'(bus.count), 64'(1));
    rv = 4'b1111; rw = {4{6'd5}};
    step(1'b0, 1'b0, '0, rv, rw, 1'b0);
    idle();
    check("dup_valid", 64'(bus.ret_valid), 64'(2'b01));
    check("dup_index", 64'(bus.ret_index), 64'(5));
    check("nord_free", 64'(bus.ret_free),  64'(0));
    check("nord_tag",  64'(bus.ret_tag),   64'(0));

    // Random traffic; wake indices mostly chosen among live entries.
    for (int i = 0; i < 1500; i++) begin
      rv = '0; rw = '0;
      for (int p = 0; p < WP; p++) begin
        rv[p] = ($urandom_range(0, 2) == 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          rw[p*IDX_W +: IDX_W] = IDX_W'((head_m + $urandom_range(0, mq.size() - 1)) % DEPTH);
        else
          rw[p*IDX_W +: IDX_W] = IDX_W'($urandom);
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), TAG_W'($urandom), rv, rw, 1'b0);
    end
    drain();

`ifdef ROB_FLUSH_EN
    repeat (5) enq(1'b1, 6'd9);
    wake1(0, head_m);
    rv = 4'b0011; rw = '0;
    rw[0*IDX_W +: IDX_W] = IDX_W'((head_m + 1) % DEPTH);
    rw[1*IDX_W +: IDX_W] = IDX_W'((head_m + 2) % DEPTH);
    step(1'b1, 1'b1, 6'd44, rv, rw, 1'b1);
    check("flush_count", 64'(bus.count),     64'(0));
    check("flush_empty", 64'(bus.empty),     64'(1));
    check("flush_index", 64'(bus.enq_index), 64'(0));
    idle();
    check("flush_noret", 64'(bus.ret_valid), 64'(0));
`endif

    // Asynchronous reset while a retire is being reported.
    enq(1'b1, 6'd3); enq(1'b1, 6'd4); enq(1'b1, 6'd6);
    rv = 4'b0011; rw = '0;
    rw[0*IDX_W +: IDX_W] = IDX_W'(head_m);
    rw[1*IDX_W +: IDX_W] = IDX_W'((head_m + 1) % DEPTH);
    step(1'b0, 1'b0, '0, rv, rw, 1'b0);
    idle();
    check("pre_rst_valid", 64'(bus.ret_valid), 64'(2'b11));
    reset = 1'b1;
    #2;
    model_clear();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    enq(1'b1, 6'd8);
    check("post_rst_index", 64'(bus.enq_index), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
